// File: rtl/onewire_pkg.sv
// ---------------------------------------------------------------------------
// onewire_pkg
// Shared definitions for the 1-Wire scratchpad receiver slice:
//   - receiver FSM state encoding
//   - reflected Dallas/Maxim CRC8 polynomial (x^8 + x^5 + x^4 + 1)
//   - default scratchpad length and system clock frequency
//   - saturating 4-bit bit-counter increment helper
// No ports (package).
// ---------------------------------------------------------------------------
package onewire_pkg;

    localparam int unsigned CLK_HZ                = 27_000_000;
    localparam int unsigned DEFAULT_SCRATCH_BYTES = 9;
    localparam logic [7:0]  CRC_POLY_REFLECTED    = 8'h8C;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_GAP,
        ST_CHECK
    } rx_state_t;

    // Sticks at 15 so a runaway read stage cannot wrap back to a legal 8.
    function automatic logic [3:0] bit_cnt_inc(input logic [3:0] cnt);
        return (cnt == 4'hF) ? cnt : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/onewire_scratchpad_rx_if.sv
// ---------------------------------------------------------------------------
// onewire_scratchpad_rx_if
// Bundles the request/read-stage/result signals of the scratchpad receiver.
//   start        host -> rx   one-cycle frame request
//   read_enable  rx -> stage  enable for the upstream per-byte read stage
//   bit_strobe   stage -> rx  one-cycle sample pulse
//   bit_in       stage -> rx  synchronised line level
//   byte_done    stage -> rx  level, 8 slots finished
//   busy         rx -> host   receiver not idle
//   temp_raw     rx -> host   {byte1, byte0} of last frame
//   crc_ok       rx -> host   last frame CRC residue was zero
//   frame_err    rx -> host   last frame had a short/long byte
//   data_valid   rx -> host   one-cycle result-update pulse
// Modports: slave = receiver side, master = host / read-stage side.
// ---------------------------------------------------------------------------
interface onewire_scratchpad_rx_if;

    logic        start;
    logic        read_enable;
    logic        bit_strobe;
    logic        bit_in;
    logic        byte_done;
    logic        busy;
    logic [15:0] temp_raw;
    logic        crc_ok;
    logic        frame_err;
    logic        data_valid;

    modport slave (
        input  start,
        input  bit_strobe,
        input  bit_in,
        input  byte_done,
        output read_enable,
        output busy,
        output temp_raw,
        output crc_ok,
        output frame_err,
        output data_valid
    );

    modport master (
        output start,
        output bit_strobe,
        output bit_in,
        output byte_done,
        input  read_enable,
        input  busy,
        input  temp_raw,
        input  crc_ok,
        input  frame_err,
        input  data_valid
    );

endinterface

// File: rtl/onewire_crc8.sv
// ---------------------------------------------------------------------------
// onewire_crc8
// Bit-serial Dallas CRC8, LSB-first, reflected polynomial 0x8C.
// Running the whole frame including the trailing CRC byte leaves zero
// in the register when the frame is intact.
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   clear   in   zero the register (wins over enable)
//   enable  in   advance by one bit this cycle
//   bit_in  in   data bit to absorb
//   crc     out  8-bit CRC register
// ---------------------------------------------------------------------------
module onewire_crc8
    import onewire_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic fb;

    always_comb begin
        fb = crc[0] ^ bit_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc <= '0;
        end else if (clear) begin
            crc <= '0;
        end else if (enable) begin
            crc <= (crc >> 1) ^ (fb ? CRC_POLY_REFLECTED : 8'h00);
        end
    end

endmodule

// File: rtl/onewire_scratchpad_rx.sv
// ---------------------------------------------------------------------------
// onewire_scratchpad_rx
// Collects a NUM_BYTES scratchpad frame (LSB byte first, LSB bit first)
// from an upstream 1-Wire read stage, checks the CRC and per-byte bit
// counts, and publishes the raw temperature word.
//   clk  in   system clock (27 MHz)
//   rst  in   synchronous active-high reset
//   bus  slave modport of onewire_scratchpad_rx_if (see interface header)
// Parameter:
//   NUM_BYTES  bytes per frame, must be >= 2
// ---------------------------------------------------------------------------
module onewire_scratchpad_rx
    import onewire_pkg::*;
#(
    parameter int unsigned NUM_BYTES = DEFAULT_SCRATCH_BYTES
) (
    input  logic                    clk,
    input  logic                    rst,
    onewire_scratchpad_rx_if.slave  bus
);

    if (NUM_BYTES < 2) begin : g_bad_num_bytes
        $error("onewire_scratchpad_rx: NUM_BYTES must be at least 2");
    end

    // Guarded so an illegal NUM_BYTES reports the error above rather than
    // tripping over a zero-width index first.
    localparam int unsigned            IDX_W    = (NUM_BYTES < 2) ? 1 : $clog2(NUM_BYTES);
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_BYTES - 1);

    rx_state_t          state;
    logic [IDX_W-1:0]   byte_idx;
    logic [3:0]         bit_cnt;
    logic [7:0]         shreg;
    logic [7:0]         buffer [NUM_BYTES];
    logic               err_acc;
    logic               gap_cnt;

    logic               strobe_rd;
    logic [7:0]         shreg_nxt;
    logic [3:0]         cnt_nxt;
    logic               crc_clear;
    logic [7:0]         crc;

    // Next shift/count values include a strobe arriving in the same cycle
    // as byte_done, so that bit lands in the stored byte and the count.
    always_comb begin
        strobe_rd = (state == ST_READ) && bus.bit_strobe;
        shreg_nxt = shreg;
        cnt_nxt   = bit_cnt;
        if (strobe_rd) begin
            shreg_nxt = {bus.bit_in, shreg[7:1]};
            cnt_nxt   = bit_cnt_inc(bit_cnt);
        end
        crc_clear = (state == ST_IDLE) && bus.start;
    end

    onewire_crc8 u_crc (
        .clk    (clk),
        .rst    (rst),
        .clear  (crc_clear),
        .enable (strobe_rd),
        .bit_in (bus.bit_in),
        .crc    (crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            byte_idx        <= '0;
            bit_cnt         <= '0;
            shreg           <= '0;
            err_acc         <= 1'b0;
            gap_cnt         <= 1'b0;
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                buffer[i] <= '0;
            end
            bus.read_enable <= 1'b0;
            bus.busy        <= 1'b0;
            bus.temp_raw    <= '0;
            bus.crc_ok      <= 1'b0;
            bus.frame_err   <= 1'b0;
            bus.data_valid  <= 1'b0;
        end else begin
            bus.data_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state           <= ST_READ;
                        byte_idx        <= '0;
                        bit_cnt         <= '0;
                        shreg           <= '0;
                        err_acc         <= 1'b0;
                        bus.read_enable <= 1'b1;
                        bus.busy        <= 1'b1;
                    end
                end

                ST_READ: begin
                    shreg   <= shreg_nxt;
                    bit_cnt <= cnt_nxt;
                    if (bus.byte_done) begin
                        buffer[byte_idx] <= shreg_nxt;
                        if (cnt_nxt != 4'd8) begin
                            err_acc <= 1'b1;
                        end
                        bit_cnt         <= '0;
                        bus.read_enable <= 1'b0;
                        if (byte_idx == LAST_IDX) begin
                            state <= ST_CHECK;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            gap_cnt  <= 1'b0;
                            state    <= ST_GAP;
                        end
                    end
                end

                // Two cycles with read_enable low give the read stage time
                // to drop byte_done before the next byte starts.
                ST_GAP: begin
                    if (gap_cnt) begin
                        state           <= ST_READ;
                        bus.read_enable <= 1'b1;
                    end else begin
                        gap_cnt <= 1'b1;
                    end
                end

                ST_CHECK: begin
                    bus.temp_raw   <= {buffer[1], buffer[0]};
                    bus.crc_ok     <= (crc == 8'h00);
                    bus.frame_err  <= err_acc;
                    bus.data_valid <= 1'b1;
                    bus.busy       <= 1'b0;
                    state          <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onewire_scratchpad_rx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_onewire_scratchpad_rx
// Directed bench: plays the upstream read stage and the host, drives frames
// byte by byte and compares results with hand-computed values.
// ---------------------------------------------------------------------------
module tb_onewire_scratchpad_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    onewire_scratchpad_rx_if bus ();

    onewire_scratchpad_rx #(.NUM_BYTES(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor samples 1 ns after each rising edge.
    int          dv_count   = 0;
    int          gap_events = 0;
    logic [15:0] cap_temp   = '0;
    logic        cap_crc    = 1'b0;
    logic        cap_err    = 1'b0;
    logic        prev_re    = 1'b0;
    logic        prev_busy  = 1'b0;

    always @(posedge clk) begin
        #1;
        if (bus.data_valid === 1'b1) begin
            dv_count++;
            cap_temp = bus.temp_raw;
            cap_crc  = bus.crc_ok;
            cap_err  = bus.frame_err;
        end
        if (prev_re === 1'b0 && prev_busy === 1'b1 && bus.read_enable === 1'b1) begin
            gap_events++;
        end
        prev_re   = bus.read_enable;
        prev_busy = bus.busy;
    end

    logic [7:0] fr [9];
    int         short_idx  = -1;
    logic [8:0] coinc_mask = '0;
    int         glitch_idx = -1;

    task automatic load_good_frame();
        fr[0] = 8'h50; fr[1] = 8'h05; fr[2] = 8'h4B; fr[3] = 8'h46; fr[4] = 8'h7F;
        fr[5] = 8'hFF; fr[6] = 8'h0C; fr[7] = 8'h10; fr[8] = 8'h1C;
        short_idx  = -1;
        coinc_mask = '0;
        glitch_idx = -1;
    endtask

    task automatic send_byte(input int k, input bit last);
        int n = 0;
        int nb;
        int g;
        bit co;
        while (bus.read_enable !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq($sformatf("read_enable_b%0d", k), bus.read_enable, 1);
        if (bus.read_enable !== 1'b1) return;

        nb = (k == short_idx) ? 7 : 8;
        co = coinc_mask[k];
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            bus.bit_in     = fr[k][i];
            bus.bit_strobe = 1'b1;
            if (co && i == nb - 1) bus.byte_done = 1'b1;
            if (k == glitch_idx && i == 0) bus.start = 1'b1;
            @(negedge clk);
            bus.bit_strobe = 1'b0;
            bus.start      = 1'b0;
        end
        if (!co) begin
            bus.byte_done = 1'b1;
            @(negedge clk);
        end
        check_eq($sformatf("re_drop_b%0d", k), bus.read_enable, 0);
        bus.byte_done = 1'b0;

        if (!last) begin
            g = 1;
            while (bus.read_enable !== 1'b1 && g < 20) begin
                @(negedge clk);
                if (bus.read_enable !== 1'b1) g++;
            end
            check_eq($sformatf("gap_len_b%0d", k), g, 2);
        end
    endtask

    task automatic run_frame(input string name, input logic [15:0] exp_temp,
                             input bit chk_crc, input logic exp_crc, input logic exp_err);
        int dv0;
        int n = 0;
        dv0        = dv_count;
        gap_events = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq({name, "_busy"}, bus.busy, 1);
        for (int k = 0; k < 9; k++) begin
            send_byte(k, k == 8);
        end
        while (dv_count == dv0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check_eq({name, "_dv_pulses"}, dv_count - dv0, 1);
        check_eq({name, "_temp_raw"}, cap_temp, exp_temp);
        if (chk_crc) check_eq({name, "_crc_ok"}, cap_crc, exp_crc);
        check_eq({name, "_frame_err"}, cap_err, exp_err);
        check_eq({name, "_gaps"}, gap_events, 8);
        check_eq({name, "_busy_end"}, bus.busy, 0);
        check_eq({name, "_temp_hold"}, bus.temp_raw, exp_temp);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dv0;
        bus.start      = 1'b0;
        bus.bit_strobe = 1'b0;
        bus.bit_in     = 1'b0;
        bus.byte_done  = 1'b0;
        rst            = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_eq("rst_read_enable", bus.read_enable, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_data_valid", bus.data_valid, 0);
        check_eq("rst_temp_raw", bus.temp_raw, 16'h0000);
        check_eq("rst_crc_ok", bus.crc_ok, 0);
        check_eq("rst_frame_err", bus.frame_err, 0);

        // Reference DS18B20 scratchpad, valid CRC.
        load_good_frame();
        run_frame("good", 16'h0550, 1, 1'b1, 1'b0);

        // Single corrupted byte: CRC must flag it, temperature bytes intact.
        load_good_frame();
        fr[2] = 8'h4A;
        run_frame("badcrc", 16'h0550, 1, 1'b0, 1'b0);

        // Byte 3 with only seven strobes.
        load_good_frame();
        short_idx = 3;
        run_frame("short", 16'h0550, 0, 1'b0, 1'b1);

        // Abort after byte 4; prior results (0550, err=1) must be wiped.
        load_good_frame();
        dv0 = dv_count;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send_byte(k, 1'b0);
        end
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_read_enable", bus.read_enable, 0);
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_temp_raw", bus.temp_raw, 16'h0000);
        check_eq("abort_crc_ok", bus.crc_ok, 0);
        check_eq("abort_frame_err", bus.frame_err, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("abort_no_dv", dv_count - dv0, 0);
        check_eq("abort_idle_re", bus.read_enable, 0);

        load_good_frame();
        run_frame("after_rst", 16'h0550, 1, 1'b1, 1'b0);

        // Every byte's last strobe coincides with byte_done; start pulsed mid-READ.
        load_good_frame();
        coinc_mask = 9'h1FF;
        glitch_idx = 3;
        run_frame("coinc", 16'h0550, 1, 1'b1, 1'b0);

        // Different temperature bytes; CRC not meaningful here.
        load_good_frame();
        fr[0] = 8'hA5;
        fr[1] = 8'h3C;
        coinc_mask = 9'h002;
        run_frame("temp2", 16'h3CA5, 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
